// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host link: FSM states, frame edge
// numbering and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        XFER,
        WAIT_IDLE
    } ps2_state_t;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_PARITY_EDGE = 9;
    localparam int PS2_STOP_EDGE   = 10;
    localparam int PS2_ACK_EDGE    = 11;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request handshake and completion status between a command source and
// the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, ack_err, timeout_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample persistence filter for one
// PS/2 pin; reports the accepted level and a one-cycle strobe on 1->0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_count;
    logic          r_level;
    logic          r_fall;

    // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_count <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_count <= '0;
            end else if (r_count == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_count <= '0;
                r_fall  <= r_level;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-edge frame clocked by
// the device, ACK check, and a per-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 15000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_tx_if.slave   bus,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_data,
    output logic           o_ps2_clk_low,
    output logic           o_ps2_data_low,
    output logic           o_rx_inhibit
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_level;
    logic w_unused_data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (i_ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (i_ps2_data),
        .o_level (w_data_level),
        .o_fall  (w_unused_data_fall)
    );

    ps2_state_t          r_state;
    logic [7:0]          r_data;
    logic                r_parity;
    logic [3:0]          r_edge;
    logic [IW-1:0]       r_inh_cnt;
    logic [TW-1:0]       r_timer;
    logic                r_ack_bad;
    logic                r_ready;
    logic                r_clk_low;
    logic                r_data_low;
    logic                r_rx_inhibit;
    logic                r_done;
    logic                r_ack_err;
    logic                r_timeout_err;

    logic w_timer_expired;
    assign w_timer_expired = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // r_edge holds the number of falls already seen, so the incoming fall is r_edge+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_data        <= '0;
            r_parity      <= 1'b0;
            r_edge        <= '0;
            r_inh_cnt     <= '0;
            r_timer       <= '0;
            r_ack_bad     <= 1'b0;
            r_ready       <= 1'b1;
            r_clk_low     <= 1'b0;
            r_data_low    <= 1'b0;
            r_rx_inhibit  <= 1'b0;
            r_done        <= 1'b0;
            r_ack_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_ack_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_low    <= 1'b0;
                    r_data_low   <= 1'b0;
                    r_rx_inhibit <= 1'b0;
                    r_ready      <= 1'b1;
                    if (r_ready && bus.tx_valid) begin
                        r_data       <= bus.tx_data;
                        r_parity     <= odd_parity(bus.tx_data);
                        r_inh_cnt    <= '0;
                        r_clk_low    <= 1'b1;
                        r_ready      <= 1'b0;
                        r_rx_inhibit <= 1'b1;
                        r_state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        r_data_low <= 1'b1;
                        r_state    <= START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + IW'(1);
                    end
                end
                START: begin
                    r_clk_low <= 1'b0;
                    r_edge    <= '0;
                    r_timer   <= '0;
                    r_state   <= XFER;
                end
                XFER: begin
                    if (w_clk_fall) begin
                        r_timer <= '0;
                        r_edge  <= r_edge + 4'd1;
                        if (r_edge < 4'(PS2_DATA_BITS)) begin
                            r_data_low <= ~r_data[r_edge[2:0]];
                        end else if (r_edge == 4'(PS2_PARITY_EDGE - 1)) begin
                            r_data_low <= ~r_parity;
                        end else if (r_edge == 4'(PS2_STOP_EDGE - 1)) begin
                            r_data_low <= 1'b0;
                        end else begin
                            r_ack_bad <= w_data_level;
                            r_state   <= WAIT_IDLE;
                        end
                    end else if (w_timer_expired) begin
                        r_clk_low     <= 1'b0;
                        r_data_low    <= 1'b0;
                        r_rx_inhibit  <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (w_clk_level && w_data_level) begin
                        r_clk_low    <= 1'b0;
                        r_data_low   <= 1'b0;
                        r_rx_inhibit <= 1'b0;
                        r_done       <= 1'b1;
                        r_ack_err    <= r_ack_bad;
                        r_state      <= IDLE;
                    end else if (w_clk_fall) begin
                        r_timer <= '0;
                    end else if (w_timer_expired) begin
                        r_clk_low     <= 1'b0;
                        r_data_low    <= 1'b0;
                        r_rx_inhibit  <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = r_ready;
    assign bus.done        = r_done;
    assign bus.ack_err     = r_ack_err;
    assign bus.timeout_err = r_timeout_err;
    assign o_ps2_clk_low   = r_clk_low;
    assign o_ps2_data_low  = r_data_low;
    assign o_rx_inhibit    = r_rx_inhibit;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural keyboard drives the
// open-drain lines and captures the frame; a monitor checks each completion.
module tb_ps2_host_tx;

    localparam int INHIB  = 200;
    localparam int TMO    = 3000;
    localparam int FLT    = 8;
    localparam int HALF   = 40;
    localparam int BUDGET = 20000;

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
        logic       ackErr;
        logic       isTimeout;
    } expItem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic hostClkLow, hostDataLow, rxInhibit;
    logic devClkLow = 1'b0, devDataLow = 1'b0, glitch = 1'b0;
    logic ps2ClkPin, ps2DataPin;
    assign ps2ClkPin  = !(hostClkLow || devClkLow || glitch);
    assign ps2DataPin = !(hostDataLow || devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIB),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .i_ps2_clk      (ps2ClkPin),
        .i_ps2_data     (ps2DataPin),
        .o_ps2_clk_low  (hostClkLow),
        .o_ps2_data_low (hostDataLow),
        .o_rx_inhibit   (rxInhibit)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    expItem_t expQ[$];

    bit          ackMode     = 1'b1;
    int          stopAfter   = 11;
    logic [11:0] glitchMask  = '0;
    bit          devAbort    = 1'b0;
    bit          devBusy     = 1'b0;
    int          devFallCount = 0;
    int          devLastFall  = 0;
    logic [7:0]  capByte     = '0;
    logic        capParity   = 1'b0;
    logic        capStop     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Keyboard model: clocks 11 edges, samples host data on each rising edge.
    task automatic runFrame();
        devBusy = 1'b1;
        devFallCount = 0;
        capByte = '0;
        capParity = 1'b0;
        capStop = 1'b0;
        waitCycles(HALF);
        for (int e = 1; e <= 11; e++) begin
            if (devAbort || e > stopAfter) break;
            if (e == 11 && ackMode) begin
                devDataLow = 1'b1;
                waitCycles(HALF / 2);
            end
            devClkLow = 1'b1;
            devFallCount = e;
            devLastFall = cycle;
            waitCycles(HALF);
            devClkLow = 1'b0;
            if (e <= 8) capByte[e-1] = ps2DataPin;
            else if (e == 9) capParity = ps2DataPin;
            else if (e == 10) capStop = ps2DataPin;
            if (glitchMask[e]) begin
                waitCycles(10);
                glitch = 1'b1;
                waitCycles(3);
                glitch = 1'b0;
                waitCycles(HALF - 13);
            end else begin
                waitCycles(HALF);
            end
        end
        devDataLow = 1'b0;
        devBusy = 1'b0;
    endtask

    initial begin : deviceModel
        forever begin
            wait (hostClkLow === 1'b1);
            wait (hostClkLow === 1'b0);
            @(posedge clk);
            #1;
            if (hostDataLow === 1'b1) runFrame();
        end
    end

    initial begin : monitor
        expItem_t e;
        bit readyPending;
        int lat;
        readyPending = 1'b0;
        forever begin
            @(negedge clk);
            if (readyPending) begin
                checkOutput("tx_ready after pulse", bus.tx_ready, 1);
                readyPending = 1'b0;
            end
            if (!rst && (bus.done || bus.timeout_err)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected pulse", {bus.done, bus.timeout_err}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done", bus.done, !e.isTimeout);
                    checkOutput("timeout_err", bus.timeout_err, e.isTimeout);
                    checkOutput("ack_err", bus.ack_err, e.ackErr);
                    checkOutput("clk_low released", hostClkLow, 0);
                    checkOutput("data_low released", hostDataLow, 0);
                    checkOutput("rx_inhibit at pulse", rxInhibit, 0);
                    checkOutput("tx_ready low at pulse", bus.tx_ready, 0);
                    if (e.isTimeout) begin
                        // Pin fall to strobe costs 2 sync + FILTER_LEN + 1 cycles, then the watchdog runs.
                        lat = cycle - devLastFall;
                        checkOutput("timeout latency in window", (lat >= TMO && lat <= TMO + 20), 1);
                    end else begin
                        checkOutput("data byte", capByte, e.data);
                        checkOutput("parity bit", capParity, e.parity);
                        checkOutput("stop bit", capStop, 1);
                    end
                    readyPending = 1'b1;
                end
            end else if (!rst && bus.ack_err) begin
                checkOutput("stray ack_err", bus.ack_err, 0);
            end
        end
    end

    initial begin : inhibitChecker
        int inhLen, startLen;
        bit aborted;
        forever begin
            @(negedge clk);
            if (hostClkLow === 1'b1) begin
                inhLen = 0;
                startLen = 0;
                aborted = 1'b0;
                while (hostClkLow === 1'b1) begin
                    if (rst) aborted = 1'b1;
                    if (hostDataLow) startLen++;
                    else inhLen++;
                    @(negedge clk);
                end
                if (!aborted) begin
                    checkOutput("inhibit length", inhLen, INHIB);
                    checkOutput("start cycles", startLen, 1);
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] data);
        int n = 0;
        while (bus.tx_ready !== 1'b1 && n < BUDGET) begin
            waitCycles(1);
            n++;
        end
        checkOutput("tx_ready before send", n < BUDGET, 1);
        bus.tx_data = data;
        bus.tx_valid = 1'b1;
        waitCycles(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parity, input logic ackErr, input logic isTimeout);
        expQ.push_back('{data, parity, ackErr, isTimeout});
        sendByte(data);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((expQ.size() != 0 || devBusy || bus.tx_ready !== 1'b1) && n < BUDGET) begin
            waitCycles(1);
            n++;
        end
        checkOutput({tag, " completes"}, n < BUDGET, 1);
    endtask

    task automatic pulseReset(input string tag);
        rst = 1'b1;
        waitCycles(1);
        @(negedge clk);
        checkOutput({tag, " clk_low"}, hostClkLow, 0);
        checkOutput({tag, " data_low"}, hostDataLow, 0);
        checkOutput({tag, " tx_ready"}, bus.tx_ready, 1);
        checkOutput({tag, " rx_inhibit"}, rxInhibit, 0);
        checkOutput({tag, " pulses"}, {bus.done, bus.ack_err, bus.timeout_err}, 0);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        rst = 1'b1;
        waitCycles(3);
        @(negedge clk);
        checkOutput("reset tx_ready", bus.tx_ready, 1);
        checkOutput("reset clk_low", hostClkLow, 0);
        checkOutput("reset data_low", hostDataLow, 0);
        checkOutput("reset rx_inhibit", rxInhibit, 0);
        checkOutput("reset pulses", {bus.done, bus.ack_err, bus.timeout_err}, 0);
        rst = 1'b0;
        waitCycles(5);

        $display("[TB] 0xED with ACK");
        applyStimulus(8'hED, 1'b1, 1'b0, 1'b0);
        waitDrain("0xED");

        $display("[TB] back-to-back 0xFF, 0x01");
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
        waitDrain("back-to-back");

        $display("[TB] missing ACK");
        ackMode = 1'b0;
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
        waitDrain("no ACK");
        ackMode = 1'b1;

        $display("[TB] device stops after edge 4");
        stopAfter = 4;
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1);
        waitDrain("timeout");
        stopAfter = 11;

        $display("[TB] reset during INHIBIT");
        sendByte(8'h55);
        waitCycles(50);
        pulseReset("rst INHIBIT");
        waitCycles(20);

        $display("[TB] reset at edge 6");
        devFallCount = 0;
        sendByte(8'hED);
        n = 0;
        while (devFallCount < 6 && n < BUDGET) begin
            waitCycles(1);
            n++;
        end
        checkOutput("device reached edge 6", n < BUDGET, 1);
        waitCycles(15);
        devAbort = 1'b1;
        pulseReset("rst edge 6");
        waitDrain("abort");
        devAbort = 1'b0;
        waitCycles(20);

        $display("[TB] clock glitches mid-frame");
        glitchMask = 12'b0001_0010_0100;
        applyStimulus(8'h96, 1'b1, 1'b0, 1'b0);
        waitDrain("glitch frame");
        glitchMask = '0;

        waitCycles(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
